// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the MIPS32 instruction-memory boot loader.
package mips32_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/mips32_word_packer.sv
// Big-endian byte-to-word packer: the fourth byte of each group produces a
// one-cycle word_valid pulse on the following cycle.
module mips32_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;
  logic        word_valid_reg;
  logic [31:0] word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg      <= '0;
      cnt_reg        <= '0;
      word_valid_reg <= 1'b0;
      word_reg       <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        shift_reg <= '0;
        cnt_reg   <= '0;
      end else if (byte_valid) begin
        shift_reg <= {shift_reg[15:0], byte_data};
        cnt_reg   <= cnt_reg + 2'd1;
        if (cnt_reg == 2'd3) begin
          word_reg       <= {shift_reg, byte_data};
          word_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign byte_cnt   = cnt_reg;
  assign word_valid = word_valid_reg;
  assign word_data  = word_reg;

endmodule

// File: rtl/mips32_imem_loader.sv
// Framed boot loader: LEN_HI, LEN_LO, 4*N payload bytes, XOR checksum.
// Writes words 0..N-1 into instruction memory and releases the core on success.
module mips32_imem_loader
  import mips32_loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  state_t              state_reg, state_next;
  logic [1:0]          err_reg, err_next;
  logic                ready_arm_reg;
  logic [7:0]          len_hi_reg;
  logic [7:0]          xor_reg;
  logic [15:0]         n_reg;
  logic [ADDR_W:0]     words_loaded_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [TMO_W-1:0]    tmo_reg;

  logic                accept;
  logic                word_last;
  logic                frame_last;
  logic                tmo_hit;
  logic                counting;
  logic                pk_clear;
  logic [1:0]          byte_cnt;
  logic [15:0]         len_word;

  assign len_word   = {len_hi_reg, in_data};
  assign accept     = in_valid & in_ready;
  assign word_last  = accept && (state_reg == PAYLOAD) && (byte_cnt == 2'd3);
  assign frame_last = (32'(words_loaded_reg) + 32'd1) == 32'(n_reg);
  assign counting   = (state_reg == LEN_LO) || (state_reg == PAYLOAD) || (state_reg == CSUM);
  assign tmo_hit    = !accept && (tmo_reg == TMO_W'(TIMEOUT - 1));
  assign pk_clear   = restart | (accept && (state_reg == IDLE));

  mips32_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_valid (accept && (state_reg == PAYLOAD)),
    .byte_data  (in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (imem_we),
    .word_data  (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    if (restart) begin
      state_next = IDLE;
      err_next   = ERR_NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) state_next = LEN_LO;
        end
        LEN_LO: begin
          if (accept) begin
            if ({16'd0, len_word} > 32'(DEPTH)) begin
              state_next = ERROR;
              err_next   = ERR_LEN;
            end else if (len_word == 16'd0) begin
              state_next = CSUM;
            end else begin
              state_next = PAYLOAD;
            end
          end else if (tmo_hit) begin
            state_next = ERROR;
            err_next   = ERR_TMO;
          end
        end
        PAYLOAD: begin
          if (word_last && frame_last) begin
            state_next = CSUM;
          end else if (tmo_hit) begin
            state_next = ERROR;
            err_next   = ERR_TMO;
          end
        end
        CSUM: begin
          if (accept) begin
            if (in_data == xor_reg) begin
              state_next = DONE;
            end else begin
              state_next = ERROR;
              err_next   = ERR_CSUM;
            end
          end else if (tmo_hit) begin
            state_next = ERROR;
            err_next   = ERR_TMO;
          end
        end
        DONE:    state_next = DONE;
        ERROR:   state_next = ERROR;
        default: state_next = IDLE;
      endcase
    end
  end

  // ready_arm_reg keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = ready_arm_reg && !restart &&
               ((state_reg == IDLE) || counting);
    core_run = (state_reg == DONE);
    load_err = (state_reg == ERROR);
    err_code = err_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_arm_reg    <= 1'b0;
      len_hi_reg       <= '0;
      xor_reg          <= '0;
      n_reg            <= '0;
      words_loaded_reg <= '0;
      addr_reg         <= '0;
      tmo_reg          <= '0;
    end else begin
      ready_arm_reg <= 1'b1;
      if (restart) begin
        xor_reg          <= '0;
        words_loaded_reg <= '0;
        tmo_reg          <= '0;
      end else begin
        if (accept) begin
          xor_reg <= (state_reg == IDLE) ? in_data : (xor_reg ^ in_data);
        end
        if (accept && (state_reg == IDLE)) begin
          len_hi_reg       <= in_data;
          words_loaded_reg <= '0;
        end
        if (accept && (state_reg == LEN_LO)) begin
          n_reg <= len_word;
        end
        // Address is the pre-increment index; the count moves with imem_we.
        if (word_last) begin
          addr_reg         <= words_loaded_reg[ADDR_W-1:0];
          words_loaded_reg <= words_loaded_reg + 1'b1;
        end
        if (accept || (state_next != state_reg)) begin
          tmo_reg <= '0;
        end else if (counting) begin
          tmo_reg <= tmo_reg + 1'b1;
        end
      end
    end
  end

  assign imem_addr    = addr_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_mips32_imem_loader.sv
// Directed bench for the boot loader: a frame-level model predicts writes and
// final status; a negedge monitor checks every imem_we pulse against it.
module tb_mips32_imem_loader;

  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 16;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic              clk;
  logic              rst_n;
  logic              restart;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              load_err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int          checks;
  int          passes;
  wr_t         exp_q[$];
  logic [31:0] wlog[$];

  mips32_imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .load_err     (load_err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_all(input bq_t q);
    logic [7:0] x;
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  // Frame-level model: queues the expected writes and predicts the final status.
  task automatic model_frame(input bq_t fr, input bit trunc,
                             output bit run, output bit err,
                             output logic [1:0] code, output int words);
    int  n;
    wr_t e;
    n = {fr[0], fr[1]};
    run = 0; err = 0; code = 2'b00; words = 0;
    if (n > DEPTH) begin
      err = 1; code = 2'b01;
      return;
    end
    for (int w = 0; w < n && (2 + 4 * w + 3) < fr.size(); w++) begin
      e.addr = w % (1 << ADDR_W);
      e.data = {fr[2 + 4 * w], fr[3 + 4 * w], fr[4 + 4 * w], fr[5 + 4 * w]};
      exp_q.push_back(e);
      words++;
    end
    if (trunc) begin
      err = 1; code = 2'b11;
      return;
    end
    if (fr[fr.size() - 1] == xor_all(fr[0:fr.size() - 2])) run = 1;
    else begin
      err = 1; code = 2'b10;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_we) begin
      wlog.push_back(imem_wdata);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_write: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("imem_addr", 32'(imem_addr), e.addr);
        chk("imem_wdata", imem_wdata, e.data);
        chk("words_at_write", 32'(words_loaded), e.addr + 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL ready_wait: got in_ready 0 for 50 cycles expected 1");
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t fr);
    foreach (fr[i]) send_byte(fr[i]);
  endtask

  task automatic end_check(input string tag, input bit run, input bit err,
                           input logic [1:0] code, input int words);
    @(negedge clk);
    chk({tag, "_core_run"}, 32'(core_run), 32'(run));
    chk({tag, "_load_err"}, 32'(load_err), 32'(err));
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
    chk({tag, "_words"}, 32'(words_loaded), words);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    #1 chk("restart_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    restart = 1'b0;
    #1;
    chk("restart_core_run", 32'(core_run), 32'd0);
    chk("restart_load_err", 32'(load_err), 32'd0);
    chk("restart_err_code", 32'(err_code), 32'd0);
    chk("restart_words", 32'(words_loaded), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    bq_t        fr;
    logic [7:0] cs;
    bit         run, err;
    logic [1:0] code;
    int         words;
    int         base;

    checks = 0; passes = 0;
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Two-word program, back-to-back, correct checksum.
    fr = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h00};
    cs = xor_all(fr);
    chk("model_csum_t1", 32'(cs), 32'h88);
    fr.push_back(cs);
    model_frame(fr, 0, run, err, code, words);
    chk("model_run_t1", 32'(run), 32'd1);
    base = wlog.size();
    send_frame(fr);
    end_check("t1", run, err, code, words);
    chk("t1_write_count", wlog.size() - base, 2);
    if (wlog.size() >= base + 2) begin
      chk("t1_word0_lit", wlog[base], 32'h20010005);
      chk("t1_word1_lit", wlog[base + 1], 32'h8C220000);
    end
    chk("t1_words_lit", 32'(words_loaded), 32'd2);
    do_restart();

    // One word, checksum inverted.
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    cs = xor_all(fr);
    chk("model_csum_t2", 32'(cs), 32'h09);
    fr.push_back(cs ^ 8'hFF);
    model_frame(fr, 0, run, err, code, words);
    chk("model_code_t2", 32'(code), 32'h2);
    send_frame(fr);
    end_check("t2", run, err, code, words);
    do_restart();

    // Length 1025 exceeds DEPTH.
    fr = '{8'h04, 8'h01};
    model_frame(fr, 0, run, err, code, words);
    base = wlog.size();
    send_frame(fr);
    end_check("t3", run, err, code, words);
    chk("t3_err_code_lit", 32'(err_code), 32'h1);
    chk("t3_no_write", wlog.size() - base, 0);
    do_restart();

    // Idle after two payload bytes: timeout exactly TIMEOUT cycles later.
    fr = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    model_frame(fr, 1, run, err, code, words);
    send_frame(fr);
    repeat (TIMEOUT) @(negedge clk);
    chk("t4_no_early_tmo", 32'(load_err), 32'd0);
    @(negedge clk);
    chk("t4_load_err", 32'(load_err), 32'(err));
    chk("t4_err_code", 32'(err_code), 32'(code));
    chk("t4_core_run", 32'(core_run), 32'd0);
    chk("t4_words", 32'(words_loaded), words);
    do_restart();

    // Byte lands on the final counted cycle: the accept wins.
    fr = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fr.push_back(xor_all(fr));
    model_frame(fr, 0, run, err, code, words);
    send_frame(fr[0:3]);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_frame(fr[4:6]);
    end_check("t5", run, err, code, words);
    do_restart();

    // Restart mid-payload, then an empty frame.
    send_frame('{8'h00, 8'h01, 8'hAA, 8'hBB});
    do_restart();
    fr = '{8'h00, 8'h00, 8'h00};
    model_frame(fr, 0, run, err, code, words);
    base = wlog.size();
    send_frame(fr);
    end_check("t6", run, err, code, words);
    chk("t6_no_write", wlog.size() - base, 0);
    do_restart();

    // Asynchronous reset mid-word, then a full one-word frame.
    send_frame('{8'h00, 8'h01, 8'h11, 8'h22});
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_we", 32'(imem_we), 32'd0);
    chk("t7_rst_ready", 32'(in_ready), 32'd0);
    chk("t7_rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_ready_again", 32'(in_ready), 32'd1);
    fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cs = xor_all(fr);
    chk("model_csum_t7", 32'(cs), 32'h23);
    fr.push_back(cs);
    model_frame(fr, 0, run, err, code, words);
    base = wlog.size();
    send_frame(fr);
    end_check("t7", run, err, code, words);
    chk("t7_write_count", wlog.size() - base, 1);
    if (wlog.size() > base) chk("t7_word_lit", wlog[base], 32'hDEADBEEF);

    chk("final_pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
